// File: rtl/mac_sched.sv
// Two-requester round-robin scheduler for a shared external multiplier.
// A tag pipeline follows the multiplier latency and feeds per-requester 40-bit accumulators.
module mac_sched #(
    parameter int LAT = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0][2:0]     req_instr,
    input  logic [1:0][15:0]    req_a,
    input  logic [1:0][15:0]    req_b,
    input  logic                stall,
    output logic signed [15:0]  mul_a,
    output logic signed [15:0]  mul_b,
    input  logic signed [31:0]  mul_result,
    output logic                rsp_valid,
    output logic                rsp_id,
    output logic [31:0]         rsp_result,
    output logic [7:0]          rsp_protect
);

    typedef struct packed {
        logic       valid;
        logic       id;
        logic [2:0] instr;
    } tag_t;

    tag_t               pipe [LAT];
    logic signed [39:0] acc  [2];
    logic               ptr;

    logic               issue;
    logic               grant_id;
    tag_t               tail;
    logic signed [39:0] prod_ext;
    logic signed [39:0] cur_acc;
    logic signed [39:0] new_val;
    logic               acc_we;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        issue     = reset_n && !stall && (req_valid != 2'b00);
        grant_id  = (req_valid == 2'b11) ? ptr : req_valid[1];
        req_ready = 2'b00;
        mul_a     = '0;
        mul_b     = '0;
        if (issue) begin
            req_ready[grant_id] = 1'b1;
            mul_a               = req_a[grant_id];
            mul_b               = req_b[grant_id];
        end
    end

    // The tag leaving the last stage lines up with mul_result for the same operation.
    always_comb begin
        tail     = pipe[LAT-1];
        prod_ext = {{8{mul_result[31]}}, mul_result};
        cur_acc  = acc[tail.id];
        new_val  = prod_ext;
        acc_we   = 1'b0;
        case (tail.instr)
            3'b000: begin
                new_val = prod_ext;
                acc_we  = 1'b1;
            end
            3'b001: begin
                new_val = cur_acc + prod_ext;
                acc_we  = 1'b1;
            end
            3'b010: begin
                new_val = cur_acc - prod_ext;
                acc_we  = 1'b1;
            end
            default: begin
                new_val = prod_ext;
                acc_we  = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // NOTE: the accumulator array is reset explicitly because a flushed op must restart from zero.
            for (int k = 0; k < LAT; k++) pipe[k] <= '0;
            for (int r = 0; r < 2; r++) acc[r] <= '0;
            ptr         <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_result  <= '0;
            rsp_protect <= '0;
        end else begin
            for (int k = LAT - 1; k > 0; k--) pipe[k] <= pipe[k-1];
            pipe[0] <= '{valid: issue, id: grant_id, instr: req_instr[grant_id]};

            if (issue) ptr <= ~grant_id;

            rsp_valid <= tail.valid;
            if (tail.valid) begin
                if (acc_we) acc[tail.id] <= new_val;
                rsp_id      <= tail.id;
                rsp_result  <= new_val[31:0];
                rsp_protect <= new_val[39:32];
            end
        end
    end

endmodule

// File: tb/tb_mac_sched.sv
// Directed bench for mac_sched with a behavioural LAT-cycle multiplier and a response scoreboard.
module tb_mac_sched;

    localparam int LAT = 3;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               stall = 1'b0;
    logic [1:0]         req_valid = '0;
    logic [1:0]         req_ready;
    logic [1:0][2:0]    req_instr = '0;
    logic [1:0][15:0]   req_a = '0;
    logic [1:0][15:0]   req_b = '0;
    logic signed [15:0] mul_a, mul_b;
    logic signed [31:0] mul_result;
    logic               rsp_valid, rsp_id;
    logic [31:0]        rsp_result;
    logic [7:0]         rsp_protect;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    mac_sched #(.LAT(LAT)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_instr(req_instr), .req_a(req_a), .req_b(req_b), .stall(stall),
        .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_protect(rsp_protect)
    );

    always #5 clk = ~clk;

    // Multiplier model: product appears LAT cycles after the operands are driven.
    logic signed [31:0] mp [LAT];
    always @(posedge clk) begin
        mp[0] <= mul_a * mul_b;
        for (int k = 1; k < LAT; k++) mp[k] <= mp[k-1];
    end
    assign mul_result = mp[LAT-1];

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic       id;
        logic [39:0] val;
    } rsp_t;
    rsp_t rsp_q[$];
    rsp_t exp_q[$];

    always @(negedge clk)
        if (rsp_valid === 1'b1) rsp_q.push_back('{cyc, rsp_id, {rsp_protect, rsp_result}});

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v,
                         input logic [2:0] i0, input logic [15:0] a0, input logic [15:0] b0,
                         input logic [2:0] i1, input logic [15:0] a1, input logic [15:0] b1);
        req_valid    = v;
        req_instr[0] = i0; req_a[0] = a0; req_b[0] = b0;
        req_instr[1] = i1; req_a[1] = a1; req_b[1] = b1;
        #1;
    endtask

    task automatic idle();
        drive(2'b00, 3'd0, 16'd0, 16'd0, 3'd0, 16'd0, 16'd0);
    endtask

    task automatic expect_rsp(input int c, input logic id, input logic [39:0] v);
        exp_q.push_back('{c, id, v});
    endtask

    task automatic check_rsps(input string tag);
        check({tag, "_count"}, 40'(rsp_q.size()), 40'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rsp_q.size(); i++) begin
            check($sformatf("%s_cyc%0d", tag, i), 40'(rsp_q[i].c), 40'(exp_q[i].c));
            check($sformatf("%s_id%0d", tag, i), 40'(rsp_q[i].id), 40'(exp_q[i].id));
            check($sformatf("%s_val%0d", tag, i), rsp_q[i].val, exp_q[i].val);
        end
        rsp_q.delete();
        exp_q.delete();
    endtask

    logic [2:0]  chain_op  [3] = '{3'b000, 3'b001, 3'b010};
    logic [15:0] chain_a   [3] = '{16'd100, 16'd100, 16'd1};
    logic [15:0] chain_b   [3] = '{16'd100, 16'd100, 16'd5};
    logic [39:0] chain_exp [3] = '{40'd10000, 40'd20000, 40'd19995};
    logic [2:0]  guard_op  [4] = '{3'b000, 3'b001, 3'b001, 3'b001};
    logic [39:0] guard_exp [4] = '{40'h00_4000_0000, 40'h00_8000_0000,
                                   40'h00_C000_0000, 40'h01_0000_0000};

    initial begin
        // Reset with both requesters asserting.
        drive(2'b11, 3'b000, 16'd1, 16'd1, 3'b000, 16'd1, 16'd1);
        step();
        step();
        check("rst_ready", 40'(req_ready), 40'h0);
        check("rst_mul_a", 40'(mul_a), 40'h0);
        check("rst_rsp_valid", 40'(rsp_valid), 40'h0);
        check("rst_rsp_val", {rsp_protect, rsp_result}, 40'h0);
        idle();
        reset_n = 1'b1;
        step();
        rsp_q.delete();

        // Single op: 3 * -4.
        drive(2'b01, 3'b000, 16'd3, -16'sd4, 3'b000, 16'd0, 16'd0);
        check("single_ready", 40'(req_ready), 40'h1);
        check("single_mul_a", 40'(mul_a), 40'd3);
        check("single_mul_b", 40'(mul_b), 40'hFF_FFFF_FFFC);
        expect_rsp(cyc + LAT + 1, 1'b0, 40'hFF_FFFF_FFF4);
        step();
        idle();
        repeat (6) step();
        check_rsps("single");
        check("hold_valid", 40'(rsp_valid), 40'h0);
        check("hold_val", {rsp_protect, rsp_result}, 40'hFF_FFFF_FFF4);

        // Back-to-back accumulate chain on requester 1.
        for (int j = 0; j < 3; j++) begin
            drive(2'b10, 3'b000, 16'd0, 16'd0, chain_op[j], chain_a[j], chain_b[j]);
            check($sformatf("chain_ready%0d", j), 40'(req_ready), 40'h2);
            expect_rsp(cyc + LAT + 1, 1'b1, chain_exp[j]);
            step();
        end
        idle();
        repeat (7) step();
        check_rsps("chain");

        // Contention: both valid, pointer at 0 -> grants alternate 0,1,0,1.
        for (int j = 0; j < 4; j++) begin
            drive(2'b11, 3'b011, 16'd2, 16'd3, 3'b011, -16'sd7, 16'd5);
            check($sformatf("rr_ready%0d", j), 40'(req_ready), (j % 2 == 0) ? 40'h1 : 40'h2);
            check($sformatf("rr_mul_a%0d", j), 40'(mul_a),
                  (j % 2 == 0) ? 40'd2 : 40'hFF_FFFF_FFF9);
            expect_rsp(cyc + LAT + 1, (j % 2 == 1), (j % 2 == 0) ? 40'd6 : 40'hFF_FFFF_FFDD);
            step();
        end
        idle();
        repeat (7) step();
        check_rsps("rr");

        // Guard bits: four accumulations of 2^30 reach 2^32.
        for (int j = 0; j < 4; j++) begin
            drive(2'b01, guard_op[j], 16'h8000, 16'h8000, 3'b000, 16'd0, 16'd0);
            expect_rsp(cyc + LAT + 1, 1'b0, guard_exp[j]);
            step();
        end
        idle();
        repeat (7) step();
        check_rsps("guard");

        // Stall blocks new issue while an earlier op completes on schedule.
        drive(2'b01, 3'b011, 16'd5, 16'd6, 3'b000, 16'd0, 16'd0);
        expect_rsp(cyc + LAT + 1, 1'b0, 40'd30);
        step();
        stall = 1'b1;
        for (int j = 0; j < 3; j++) begin
            drive(2'b01, 3'b011, 16'd1, 16'd1, 3'b000, 16'd0, 16'd0);
            check($sformatf("stall_ready%0d", j), 40'(req_ready), 40'h0);
            check($sformatf("stall_mul_a%0d", j), 40'(mul_a), 40'h0);
            step();
        end
        stall = 1'b0;
        drive(2'b01, 3'b011, 16'd1, 16'd1, 3'b000, 16'd0, 16'd0);
        check("unstall_ready", 40'(req_ready), 40'h1);
        expect_rsp(cyc + LAT + 1, 1'b0, 40'd1);
        step();
        idle();
        repeat (6) step();
        check_rsps("stall");

        // Reset while two accumulates are in flight.
        drive(2'b01, 3'b001, 16'd2, 16'd3, 3'b000, 16'd0, 16'd0);
        step();
        drive(2'b01, 3'b001, 16'd2, 16'd3, 3'b000, 16'd0, 16'd0);
        step();
        idle();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("flush_rsp_val", {rsp_protect, rsp_result}, 40'h0);
        repeat (6) step();
        check_rsps("flush");
        drive(2'b01, 3'b001, 16'd2, 16'd3, 3'b000, 16'd0, 16'd0);
        expect_rsp(cyc + LAT + 1, 1'b0, 40'd6);
        step();
        idle();
        repeat (6) step();
        check_rsps("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
